// File: rtl/sequenciador_soma_sub.sv
// sequenciador_soma_sub
// Sequencing and result-capture stage around an external 4-bit
// adder/subtractor. It accepts one operation per input handshake and drives
// stable operands to the adder for ESPERA cycles. It then captures the adder's
// 5-bit result and offers it downstream with a valid/ready handshake.
//
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   entrada_valida/pronta - upstream handshake for one operation
//   operando_a/b, modo    - operands and mode (0 add, 1 subtract)
//   acumular              - 1: operand A is the low nibble of the last result
//   somador_A/B/M         - held operands to the adder
//   somador_resultado     - adder output, sampled after the settling window
//   saida_valida/pronta   - downstream handshake for the captured result
//   resultado, negativo   - captured result and (subtract & bit 4) flag
//   contador_ops          - completed output handshakes, wrapping
module sequenciador_soma_sub #(
  parameter int ESPERA       = 1,
  parameter int LARGURA_CONT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  input  logic [3:0]              operando_a,
  input  logic [3:0]              operando_b,
  input  logic                    modo,
  input  logic                    acumular,
  output logic [3:0]              somador_A,
  output logic [3:0]              somador_B,
  output logic                    somador_M,
  input  logic [4:0]              somador_resultado,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  output logic [4:0]              resultado,
  output logic                    negativo,
  output logic [LARGURA_CONT-1:0] contador_ops
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALCULA = 2'd1;
  localparam logic [1:0] ENTREGA = 2'd2;

  // Counter start value: capture happens on the ESPERA-th edge after acceptance.
  localparam logic [3:0] ESPERA_INI = 4'(ESPERA - 1);

  logic [1:0]              estado_q, estado_d;
  logic [3:0]              espera_q, espera_d;
  logic [3:0]              som_a_q, som_a_d;
  logic [3:0]              som_b_q, som_b_d;
  logic                    som_m_q, som_m_d;
  logic [4:0]              resultado_q, resultado_d;
  logic                    negativo_q, negativo_d;
  logic [LARGURA_CONT-1:0] contador_q, contador_d;
  logic                    entrada_pronta_q, entrada_pronta_d;
  logic                    saida_valida_q, saida_valida_d;

  // Next-state and datapath update for the OCIOSO/CALCULA/ENTREGA sequencer.
  always_comb begin
    estado_d    = estado_q;
    espera_d    = espera_q;
    som_a_d     = som_a_q;
    som_b_d     = som_b_q;
    som_m_d     = som_m_q;
    resultado_d = resultado_q;
    negativo_d  = negativo_q;
    contador_d  = contador_q;
    case (estado_q)
      OCIOSO: begin
        if (entrada_valida) begin
          // Accumulate drops bit 4 of the previous result.
          som_a_d  = acumular ? resultado_q[3:0] : operando_a;
          som_b_d  = operando_b;
          som_m_d  = modo;
          espera_d = ESPERA_INI;
          estado_d = CALCULA;
        end else begin
          estado_d = OCIOSO;
        end
      end
      CALCULA: begin
        if (espera_q == 4'd0) begin
          resultado_d = somador_resultado;
          negativo_d  = som_m_q & somador_resultado[4];
          estado_d    = ENTREGA;
        end else begin
          espera_d = espera_q - 4'd1;
        end
      end
      ENTREGA: begin
        // No bypass: a new operation is only looked at once back in OCIOSO.
        if (saida_pronta) begin
          contador_d = contador_q + LARGURA_CONT'(1);
          estado_d   = OCIOSO;
        end else begin
          estado_d = ENTREGA;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    // Handshake flags are registered from the next state so they line up with it.
    entrada_pronta_d = (estado_d == OCIOSO);
    saida_valida_d   = (estado_d == ENTREGA);
  end

  // State and output registers; reset returns to an idle, ready block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      espera_q         <= 4'd0;
      som_a_q          <= 4'd0;
      som_b_q          <= 4'd0;
      som_m_q          <= 1'b0;
      resultado_q      <= 5'd0;
      negativo_q       <= 1'b0;
      contador_q       <= '0;
      entrada_pronta_q <= 1'b1;
      saida_valida_q   <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      espera_q         <= espera_d;
      som_a_q          <= som_a_d;
      som_b_q          <= som_b_d;
      som_m_q          <= som_m_d;
      resultado_q      <= resultado_d;
      negativo_q       <= negativo_d;
      contador_q       <= contador_d;
      entrada_pronta_q <= entrada_pronta_d;
      saida_valida_q   <= saida_valida_d;
    end
  end

  assign entrada_pronta = entrada_pronta_q;
  assign saida_valida   = saida_valida_q;
  assign somador_A      = som_a_q;
  assign somador_B      = som_b_q;
  assign somador_M      = som_m_q;
  assign resultado      = resultado_q;
  assign negativo       = negativo_q;
  assign contador_ops   = contador_q;

endmodule

// File: doc/sequenciador_soma_sub.md
Name: sequenciador_soma_sub

Overview:
- Sequencing and result-capture stage wrapped around the 4-bit adder/subtractor (ports A[3:0], B[3:0], M, resultado[4:0]).
- Accepts one operation per handshake and drives stable A/B/M to the adder for a settling window.
- Samples the adder's 5-bit result into a register and offers it downstream with a valid/ready handshake.
- Supports accumulate mode: the previous result's low nibble becomes operand A.

Parameters:
ESPERA, 1, number of cycles A/B/M are held stable before sampling the adder result; legal range 1..15.
LARGURA_CONT, 8, width of the completed-operation counter.

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
entrada_valida  input  1  upstream has an operation to issue
entrada_pronta  output  1  block accepts an operation this cycle
operando_a  input  4  operand A (ignored when acumular=1)
operando_b  input  4  operand B
modo  input  1  0 = add, 1 = subtract
acumular  input  1  1 = use resultado_reg[3:0] as A
somador_A  output  4  to adder input A
somador_B  output  4  to adder input B
somador_M  output  1  to adder input M
somador_resultado  input  5  from adder output resultado
saida_valida  output  1  result available
saida_pronta  input  1  downstream accepts result
resultado  output  5  registered adder result
negativo  output  1  registered: modo_reg & result bit 4
contador_ops  output  LARGURA_CONT  number of completed output handshakes

Behaviour:
- Reset (async, any state): state=OCIOSO; somador_A/B=0; somador_M=0; resultado=0; negativo=0; saida_valida=0; contador_ops=0; wait counter=0. Any in-flight operation is discarded.
- Reset value of entrada_pronta: 1, because OCIOSO is entered immediately.
- FSM states: OCIOSO, CALCULA, ENTREGA.
- OCIOSO:
  - entrada_pronta=1; saida_valida=0.
  - On an edge with entrada_valida=1: latch somador_A = (acumular ? resultado[3:0] : operando_a), somador_B = operando_b, somador_M = modo.
  - Same edge: load wait counter = ESPERA-1 and go to CALCULA.
- CALCULA:
  - entrada_pronta=0; somador_A/B/M are held constant.
  - Wait counter decrements each edge.
  - On the edge where the counter equals 0: resultado <= somador_resultado, negativo <= somador_M & somador_resultado[4]; go to ENTREGA.
- ENTREGA:
  - saida_valida=1; entrada_pronta=0; resultado and negativo are held stable.
  - On an edge with saida_pronta=1: contador_ops increments, wrapping from 2^LARGURA_CONT-1 to 0; go to OCIOSO.
  - saida_valida stays high until that handshake completes.
- Latency:
  - saida_valida rises ESPERA cycles after the acceptance edge.
  - Minimum throughput is one operation per ESPERA+2 cycles.
- No bypass: entrada_valida is ignored outside OCIOSO, including in the cycle where an ENTREGA handshake completes. The next operation is accepted in the following cycle at the earliest.
- Result format (as produced by the adder):
  - modo=0: 5-bit unsigned sum; bit 4 is the carry.
  - modo=1: 5-bit two's-complement difference; bit 4 is the sign (A<B).
- Accumulate mode:
  - Uses the last captured resultado[3:0]; bit 4 is dropped.
  - After reset, that value is 0.
- somador_A/B/M change only on an acceptance edge or on reset.

Test Plan:
1. Reset, then add 9+9 (acumular=0, ESPERA=1) with a behavioural adder model -> saida_valida 1 cycle after acceptance; resultado=5'b10010; negativo=0; contador_ops=1 after the handshake.
2. Subtract 3-5 -> resultado=5'b11110 (-2); negativo=1. Subtract 5-3 -> resultado=5'b00010; negativo=0.
3. Accumulate chain: 4+3 (acumular=0), then +2 (acumular=1, operando_a=15 ignored) -> second resultado=5'b01001. Hold saida_pronta=0 for 5 cycles -> resultado is stable, entrada_pronta=0, and a new entrada_valida is not accepted.
4. ESPERA=4: change somador_resultado in the bench during CALCULA -> only the value present at the 4th edge after acceptance is captured; somador_A/B/M stay constant throughout.
5. Assert reset asynchronously mid-CALCULA and mid-ENTREGA -> all outputs take reset values immediately; entrada_pronta=1; no contador_ops increment.
6. Run 256 back-to-back operations with saida_pronta=1 and entrada_valida=1 -> contador_ops wraps to 0; acceptances are spaced exactly ESPERA+2 cycles apart.
